// File: rtl/control_sequencer.sv
// control_sequencer: microcode sequencer for the 8-bit shared-bus CPU.
// Steps a T-state counter through fetch (T0, T1) and execute (T2..T4).
// It decodes opcode, T-state and flags into the datapath control strobes.
// Optional build macro SEQ_SINGLE_STEP_EN adds a `step` input. With it, the
// counter advances and the strobes are asserted only on cycles where step=1.
//
// T-state | meaning
// T0      | fetch: PC onto bus, latch MAR
// T1      | fetch: RAM onto bus, latch IR, increment PC
// T2      | execute step 1 (every opcode; last step for 1-step opcodes)
// T3      | execute step 2 (LDA, STA, ADD, SUB)
// T4      | execute step 3 (ADD, SUB)
// halted  | HLT retired: counter parked at T0, strobes 0 until reset_n
module control_sequencer #(
   parameter  int OPCODE_W = 4,
   parameter  int NSTEPS   = 5,
   localparam int TW       = $clog2(NSTEPS)
) (
   input  logic                clock,
   input  logic                reset_n,
`ifdef SEQ_SINGLE_STEP_EN
   input  logic                step,
`endif
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                flag_carry,
   input  logic                flag_zero,
   output logic [TW-1:0]       tstate,
   output logic                halted,
   output logic                pc_read,
   output logic                pc_write,
   output logic                pc_inc,
   output logic                mar_write,
   output logic                ram_read,
   output logic                ram_write,
   output logic                ir_read,
   output logic                ir_write,
   output logic                a_read,
   output logic                a_write,
   output logic                b_write,
   output logic                alu_read,
   output logic                alu_sub,
   output logic                out_write,
   output logic                flags_write
);

   localparam logic [TW-1:0] T0 = TW'(0);
   localparam logic [TW-1:0] T1 = TW'(1);
   localparam logic [TW-1:0] T2 = TW'(2);
   localparam logic [TW-1:0] T3 = TW'(3);
   localparam logic [TW-1:0] T4 = TW'(4);

   localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(4'h1);
   localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(4'h2);
   localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(4'h3);
   localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(4'h4);
   localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(4'h5);
   localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(4'h6);
   localparam logic [OPCODE_W-1:0] OP_JC  = OPCODE_W'(4'h7);
   localparam logic [OPCODE_W-1:0] OP_JZ  = OPCODE_W'(4'h8);
   localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(4'hE);
   localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(4'hF);

   logic [TW-1:0] tstate_q, tstate_d;
   logic          halted_q, halted_d;

   logic          last_step;
   logic          advance;
   logic          ctl_en;

   logic pc_read_r, pc_write_r, pc_inc_r, mar_write_r, ram_read_r, ram_write_r;
   logic ir_read_r, ir_write_r, a_read_r, a_write_r, b_write_r;
   logic alu_read_r, alu_sub_r, out_write_r, flags_write_r;

`ifdef SEQ_SINGLE_STEP_EN
   assign advance = step;
`else
   assign advance = 1'b1;
`endif

   // Strobes are killed combinationally by reset, by halt and (single-step build) by step=0.
   assign ctl_en = reset_n & ~halted_q & advance;

   // Microcode decode: raw strobes and end-of-instruction from T-state, opcode and flags.
   always_comb begin
      pc_read_r     = 1'b0;
      pc_write_r    = 1'b0;
      pc_inc_r      = 1'b0;
      mar_write_r   = 1'b0;
      ram_read_r    = 1'b0;
      ram_write_r   = 1'b0;
      ir_read_r     = 1'b0;
      ir_write_r    = 1'b0;
      a_read_r      = 1'b0;
      a_write_r     = 1'b0;
      b_write_r     = 1'b0;
      alu_read_r    = 1'b0;
      alu_sub_r     = 1'b0;
      out_write_r   = 1'b0;
      flags_write_r = 1'b0;
      last_step     = 1'b1;
      case (tstate_q)
         T0: begin
            pc_read_r   = 1'b1;
            mar_write_r = 1'b1;
            last_step   = 1'b0;
         end
         T1: begin
            ram_read_r = 1'b1;
            ir_write_r = 1'b1;
            pc_inc_r   = 1'b1;
            last_step  = 1'b0;
         end
         T2: begin
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                  ir_read_r   = 1'b1;
                  mar_write_r = 1'b1;
                  last_step   = 1'b0;
               end
               OP_LDI: begin
                  ir_read_r = 1'b1;
                  a_write_r = 1'b1;
               end
               OP_JMP: begin
                  ir_read_r  = 1'b1;
                  pc_write_r = 1'b1;
               end
               OP_JC: begin
                  ir_read_r  = flag_carry;
                  pc_write_r = flag_carry;
               end
               OP_JZ: begin
                  ir_read_r  = flag_zero;
                  pc_write_r = flag_zero;
               end
               OP_OUT: begin
                  a_read_r    = 1'b1;
                  out_write_r = 1'b1;
               end
               default: ;
            endcase
         end
         T3: begin
            case (opcode)
               OP_LDA: begin
                  ram_read_r = 1'b1;
                  a_write_r  = 1'b1;
               end
               OP_STA: begin
                  a_read_r    = 1'b1;
                  ram_write_r = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  ram_read_r = 1'b1;
                  b_write_r  = 1'b1;
                  last_step  = 1'b0;
               end
               default: ;
            endcase
         end
         T4: begin
            if (opcode == OP_ADD || opcode == OP_SUB) begin
               alu_read_r    = 1'b1;
               a_write_r     = 1'b1;
               flags_write_r = 1'b1;
               alu_sub_r     = (opcode == OP_SUB);
            end
         end
         default: ;
      endcase
   end

   // Counter and halt next-state; any unexpected T-state or opcode falls back to T0.
   always_comb begin
      tstate_d = tstate_q;
      halted_d = halted_q;
      if (!halted_q && advance) begin
         if (last_step) tstate_d = T0;
         else           tstate_d = tstate_q + TW'(1);
         if (tstate_q == T2 && opcode == OP_HLT) halted_d = 1'b1;
      end
   end

   // Sequencer state registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tstate_q <= T0;
         halted_q <= 1'b0;
      end else begin
         tstate_q <= tstate_d;
         halted_q <= halted_d;
      end
   end

   assign tstate      = tstate_q;
   assign halted      = halted_q;
   assign pc_read     = pc_read_r     & ctl_en;
   assign pc_write    = pc_write_r    & ctl_en;
   assign pc_inc      = pc_inc_r      & ctl_en;
   assign mar_write   = mar_write_r   & ctl_en;
   assign ram_read    = ram_read_r    & ctl_en;
   assign ram_write   = ram_write_r   & ctl_en;
   assign ir_read     = ir_read_r     & ctl_en;
   assign ir_write    = ir_write_r    & ctl_en;
   assign a_read      = a_read_r      & ctl_en;
   assign a_write     = a_write_r     & ctl_en;
   assign b_write     = b_write_r     & ctl_en;
   assign alu_read    = alu_read_r    & ctl_en;
   assign alu_sub     = alu_sub_r     & ctl_en;
   assign out_write   = out_write_r   & ctl_en;
   assign flags_write = flags_write_r & ctl_en;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: random instruction stream against a microprogram-table model.
module tb_control_sequencer;

   localparam int PCR = 14, PCW = 13, PCI = 12, MARW = 11, RAMR = 10, RAMW = 9;
   localparam int IRR = 8, IRW = 7, AR = 6, AW = 5, BW = 4, ALUR = 3, ALUS = 2;
   localparam int OUTW = 1, FLW = 0;

   logic       clock = 1'b0;
   logic       reset_n;
   logic [3:0] opcode;
   logic       flag_carry, flag_zero;
   logic [2:0] tstate;
   logic       halted;
   logic pc_read, pc_write, pc_inc, mar_write, ram_read, ram_write, ir_read, ir_write;
   logic a_read, a_write, b_write, alu_read, alu_sub, out_write, flags_write;
`ifdef SEQ_SINGLE_STEP_EN
   logic       step;
`endif

   logic [14:0] ctl_vec;
   logic [14:0] ucode [16][3];
   int          ulen  [16];
   logic [14:0] rd_mask;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clock = ~clock;

   control_sequencer dut (
      .clock       (clock),
      .reset_n     (reset_n),
`ifdef SEQ_SINGLE_STEP_EN
      .step        (step),
`endif
      .opcode      (opcode),
      .flag_carry  (flag_carry),
      .flag_zero   (flag_zero),
      .tstate      (tstate),
      .halted      (halted),
      .pc_read     (pc_read),
      .pc_write    (pc_write),
      .pc_inc      (pc_inc),
      .mar_write   (mar_write),
      .ram_read    (ram_read),
      .ram_write   (ram_write),
      .ir_read     (ir_read),
      .ir_write    (ir_write),
      .a_read      (a_read),
      .a_write     (a_write),
      .b_write     (b_write),
      .alu_read    (alu_read),
      .alu_sub     (alu_sub),
      .out_write   (out_write),
      .flags_write (flags_write)
   );

   assign ctl_vec = {pc_read, pc_write, pc_inc, mar_write, ram_read, ram_write, ir_read,
                     ir_write, a_read, a_write, b_write, alu_read, alu_sub, out_write, flags_write};

   function automatic logic [14:0] sb(input int i);
      return 15'(1) << i;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   // Execute microprogram per opcode; anything not listed is a one-step no-op.
   task automatic load_ucode();
      for (int o = 0; o < 16; o++) begin
         ulen[o] = 1;
         for (int k = 0; k < 3; k++) ucode[o][k] = '0;
      end
      ulen[1] = 2; ucode[1][0] = sb(IRR) | sb(MARW); ucode[1][1] = sb(RAMR) | sb(AW);
      ulen[2] = 3; ucode[2][0] = sb(IRR) | sb(MARW); ucode[2][1] = sb(RAMR) | sb(BW);
      ucode[2][2] = sb(ALUR) | sb(AW) | sb(FLW);
      ulen[3] = 3; ucode[3][0] = sb(IRR) | sb(MARW); ucode[3][1] = sb(RAMR) | sb(BW);
      ucode[3][2] = sb(ALUR) | sb(AW) | sb(FLW) | sb(ALUS);
      ulen[4] = 2; ucode[4][0] = sb(IRR) | sb(MARW); ucode[4][1] = sb(AR) | sb(RAMW);
      ucode[5][0]  = sb(IRR) | sb(AW);
      ucode[6][0]  = sb(IRR) | sb(PCW);
      ucode[7][0]  = sb(IRR) | sb(PCW);
      ucode[8][0]  = sb(IRR) | sb(PCW);
      ucode[14][0] = sb(AR) | sb(OUTW);
      rd_mask = sb(PCR) | sb(RAMR) | sb(IRR) | sb(AR) | sb(ALUR);
   endtask

   function automatic logic [14:0] model_mask(input int op, input int s, input bit c, input bit z);
      if (s == 0) return sb(PCR) | sb(MARW);
      if (s == 1) return sb(RAMR) | sb(IRW) | sb(PCI);
      if ((op == 7 && !c) || (op == 8 && !z)) return '0;
      return ucode[op][s-2];
   endfunction

   task automatic check_cycle(input logic [14:0] em, input int et, input bit eh);
      chk("strobes", 32'(ctl_vec), 32'(em));
      chk("tstate", 32'(tstate), 32'(et));
      chk("halted", 32'(halted), 32'(eh));
      chk("bus_excl", 32'($countones(ctl_vec & rd_mask) <= 1), 32'd1);
   endtask

   // Called at posedge+1 or later; returns at posedge+1 with the DUT back in T0.
   task automatic pulse_reset();
      reset_n = 1'b0;
      #1;
      check_cycle('0, 0, 1'b0);
      @(posedge clock); #1;
      chk("reset_hold_t", 32'(tstate), 32'd0);
      reset_n = 1'b1;
   endtask

   // Entry/exit at posedge+1. cf/zf < 0 means randomize that flag each cycle.
   task automatic run_instr(input int op, input int abort_at, input int cf, input int zf,
                            output bit aborted);
      int n;
      n = 2 + ulen[op];
      aborted = 1'b0;
      for (int s = 0; s < n; s++) begin
         opcode     = 4'(op);
         flag_carry = (cf < 0) ? 1'($urandom) : 1'(cf);
         flag_zero  = (zf < 0) ? 1'($urandom) : 1'(zf);
         #2;
         check_cycle(model_mask(op, s, flag_carry, flag_zero), s, 1'b0);
         if (s == abort_at) begin
            pulse_reset();
            aborted = 1'b1;
            return;
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic halt_phase(input int ncyc);
      for (int i = 0; i < ncyc; i++) begin
         opcode     = 4'($urandom);
         flag_carry = 1'($urandom);
         flag_zero  = 1'($urandom);
         #2;
         check_cycle('0, 0, 1'b1);
         @(posedge clock); #1;
      end
   endtask

   initial begin
      bit ab;
      int op, len, abort_at;
      load_ucode();
      reset_n    = 1'b0;
      opcode     = 4'h0;
      flag_carry = 1'b0;
      flag_zero  = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
      step       = 1'b1;
`endif
      #1;
      check_cycle('0, 0, 1'b0);
      @(posedge clock); #1;
      reset_n = 1'b1;

      // Abort LDA in T3, then a full LDA, SUB, JC both ways, JZ both ways.
      run_instr(1, 3, -1, -1, ab);
      run_instr(1, -1, -1, -1, ab);
      run_instr(3, -1, -1, -1, ab);
      run_instr(7, -1, 0, -1, ab);
      run_instr(7, -1, 1, -1, ab);
      run_instr(8, -1, -1, 0, ab);
      run_instr(8, -1, -1, 1, ab);
      run_instr(15, -1, -1, -1, ab);
      halt_phase(10);
      pulse_reset();

`ifdef SEQ_SINGLE_STEP_EN
      // LDA stopped in T3 with step low: frozen and dark until one step pulse.
      step = 1'b1;
      opcode = 4'h1;
      for (int i = 0; i < 3; i++) begin @(posedge clock); #1; end
      step = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #2;
         chk("ss_hold_t", 32'(tstate), 32'd3);
         chk("ss_hold_strb", 32'(ctl_vec), 32'd0);
         @(posedge clock); #1;
      end
      step = 1'b1;
      #2;
      chk("ss_pulse_strb", 32'(ctl_vec), 32'(sb(RAMR) | sb(AW)));
      @(posedge clock); #1;
      step = 1'b0;
      #2;
      chk("ss_after_t", 32'(tstate), 32'd0);
      chk("ss_after_strb", 32'(ctl_vec), 32'd0);
      @(posedge clock); #1;
      chk("ss_idle_t", 32'(tstate), 32'd0);
      step = 1'b1;
`endif

      // Random instruction stream with occasional mid-instruction resets.
      for (int i = 0; i < 250; i++) begin
         op       = $urandom_range(0, 15);
         len      = 2 + ulen[op];
         abort_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, len - 1) : -1;
         run_instr(op, abort_at, -1, -1, ab);
         if (op == 15 && !ab) begin
            halt_phase($urandom_range(2, 6));
            pulse_reset();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
